// File: rtl/pc_sequencer_if.sv
// Instruction-fetch and issue bus between pc_sequencer and the RAM/datapath.
interface pc_sequencer_if;
    logic [15:0] instr_addr;
    logic [15:0] instr_rddata;
    logic [15:0] ir;
    logic [15:0] imm;
    logic        issue;
    logic        exec_done;
    logic        cmp_true;
    logic [15:0] rd_data;

    modport master (
        output instr_addr, ir, imm, issue,
        input  instr_rddata, exec_done, cmp_true, rd_data
    );

    modport slave (
        input  instr_addr, ir, imm, issue,
        output instr_rddata, exec_done, cmp_true, rd_data
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/issue controller: owns the PC, fetches 1/2-word instructions, resolves next-PC.
// Optional retired-instruction counter enabled by defining PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    pc_sequencer_if.master     bus,
    output logic [15:0]        pc,
    output logic               halted,
    output logic               fault
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]        retired_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WORD1, S_WORD2, S_ISSUE, S_EXEC, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       imm_q, imm_d;
    logic              issue_q, issue_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [15:0]       stack_q [STACK_DEPTH];
    logic              stack_we;
    logic [IDX_W-1:0]  stack_widx;
    logic              retire;
    logic              resolve;

    // CAL is always 2 words; its type bit is set anyway, the explicit test keeps intent clear.
    function automatic logic two_word(input logic [15:0] w);
        return (w[15:11] == 5'b00001) || w[11];
    endfunction

    logic        is_stp, is_cal, is_rtn, is_cmp, is_jmp;
    logic [15:0] len_q;

    assign is_stp = (ir_q[15:11] == 5'b11111);
    assign is_cal = (ir_q[15:11] == 5'b00001);
    assign is_rtn = (ir_q[15:11] == 5'b11100);
    assign is_cmp = (ir_q[15:12] == 4'b0001);
    assign is_jmp = (ir_q[15:12] == 4'b0010);
    assign len_q  = two_word(ir_q) ? 16'd2 : 16'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        issue_d    = 1'b0;
        halted_d   = halted_q;
        fault_d    = fault_q;
        sp_d       = sp_q;
        stack_we   = 1'b0;
        stack_widx = IDX_W'(sp_q);
        retire     = 1'b0;
        resolve    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            // Second-word address is presented speculatively so a 2-word fetch costs one extra cycle.
            S_FETCH: begin
                addr_d  = pc_q + 16'd1;
                state_d = S_WORD1;
            end
            S_WORD1: begin
                ir_d = bus.instr_rddata;
                if (two_word(bus.instr_rddata)) begin
                    state_d = S_WORD2;
                end else begin
                    imm_d   = 16'h0000;
                    issue_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_WORD2: begin
                imm_d   = bus.instr_rddata;
                issue_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (is_stp) begin
                    retire   = 1'b1;
                    halted_d = 1'b1;
                    addr_d   = pc_q;
                    state_d  = S_HALT;
                end else if (bus.exec_done) begin
                    retire  = 1'b1;
                    resolve = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    retire  = 1'b1;
                    resolve = 1'b1;
                end
            end
            S_HALT: begin
                if (run) begin
                    halted_d = 1'b0;
                    pc_d     = pc_q + 16'd1;
                    addr_d   = pc_q + 16'd1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Next-PC resolution; stack faults park in HALT with pc unchanged.
        if (resolve) begin
            state_d = S_FETCH;
            if (is_jmp) begin
                pc_d = ir_q[11] ? imm_q : bus.rd_data;
            end else if (is_cmp) begin
                pc_d = pc_q + len_q + (bus.cmp_true ? 16'(ir_q[1:0]) : 16'd0);
            end else if (is_cal) begin
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    stack_we = 1'b1;
                    sp_d     = sp_q + SP_W'(1);
                    pc_d     = imm_q;
                end
            end else if (is_rtn) begin
                if (sp_q == '0) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    sp_d = sp_q - SP_W'(1);
                    pc_d = stack_q[IDX_W'(sp_q - SP_W'(1))];
                end
            end else begin
                pc_d = pc_q + len_q;
            end
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            ir_q     <= '0;
            imm_q    <= '0;
            issue_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            sp_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            issue_q  <= issue_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            sp_q     <= sp_d;
        end
    end

    // Stack entries above sp are dead, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && stack_we) stack_q[stack_widx] <= pc_q + 16'd2;
    end

`ifdef PC_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)       retired_cnt <= '0;
        else if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
`endif

    assign bus.instr_addr = addr_q;
    assign bus.ir         = ir_q;
    assign bus.imm        = imm_q;
    assign bus.issue      = issue_q;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected issue records are queued per program and
// checked by a monitor on every issue pulse; state checks are made inline.
module tb_pc_sequencer;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] imm;
    } exp_t;

    logic clk;
    logic reset;
    logic run;
    logic [15:0] pc;
    logic halted;
    logic fault;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    pc_sequencer_if bus();

    pc_sequencer #(.STACK_DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .bus    (bus),
        .pc     (pc),
        .halted (halted),
        .fault  (fault)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    logic [15:0] mem [0:65535];
    exp_t sbq[$];
    int n_vec;
    int n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency.
    always @(posedge clk) bus.instr_rddata <= mem[bus.instr_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.issue) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_issue: got pc=%h ir=%h with nothing expected", pc, bus.ir);
                end else begin
                    e = sbq.pop_front();
                    chk("issue_pc",  32'(pc),      32'(e.pc));
                    chk("issue_ir",  32'(bus.ir),  32'(e.ir));
                    chk("issue_imm", 32'(bus.imm), 32'(e.imm));
                end
            end
        end
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] p, input logic [15:0] i, input logic [15:0] m);
        exp_t e;
        e.pc = p; e.ir = i; e.imm = m;
        sbq.push_back(e);
    endtask

    task automatic start;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    // Pulses run and returns the cycle count until the first issue is visible.
    task automatic start_count(input string name, output int cyc);
        cyc = 0;
        run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            cyc++;
            run = 1'b0;
            if (bus.issue) break;
        end
        if (!bus.issue) chk({name, "_timeout"}, 32'(bus.issue), 32'd1);
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300; k++) begin
            if (sbq.size() == 0 && halted) break;
            tick();
        end
        chk({name, "_drained"}, 32'(sbq.size()), 32'd0);
        chk({name, "_halted"},  32'(halted),     32'd1);
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        run = 1'b0;
        bus.exec_done = 1'b0;
        bus.cmp_true  = 1'b0;
        bus.rd_data   = 16'h0000;
        clear_mem();
        fork
            monitor();
        join_none

        // Reset values
        do_reset();
        chk("rst_pc",     32'(pc),             32'h0000);
        chk("rst_addr",   32'(bus.instr_addr), 32'h0000);
        chk("rst_ir",     32'(bus.ir),         32'h0000);
        chk("rst_imm",    32'(bus.imm),        32'h0000);
        chk("rst_issue",  32'(bus.issue),      32'd0);
        chk("rst_halted", 32'(halted),         32'd0);
        chk("rst_fault",  32'(fault),          32'd0);

        // 1-word ADD then STP
        mem[0] = 16'h4000; mem[1] = 16'hF800;
        bus.exec_done = 1'b1;
        push(16'h0000, 16'h4000, 16'h0000);
        push(16'h0001, 16'hF800, 16'h0000);
        start_count("add", cyc);
        chk("add_issue_cycle", 32'(cyc), 32'd3);
        tick();
        chk("add_issue_width", 32'(bus.issue), 32'd0);
        chk("add_next_pc",     32'(pc),        32'h0001);
        wait_done("add");
        chk("add_stp_pc",    32'(pc),    32'h0001);
        chk("add_stp_fault", 32'(fault), 32'd0);

        // JMP type 1 to 0050
        clear_mem();
        do_reset();
        mem[0] = 16'h2800; mem[1] = 16'h0050; mem[16'h0050] = 16'hF800;
        push(16'h0000, 16'h2800, 16'h0050);
        push(16'h0050, 16'hF800, 16'h0000);
        start_count("jmp", cyc);
        chk("jmp_issue_cycle", 32'(cyc), 32'd4);
        tick();
        chk("jmp_addr", 32'(bus.instr_addr), 32'h0050);
        chk("jmp_pc",   32'(pc),             32'h0050);
        wait_done("jmp");

        // CMP skip at 0010, ir[1:0]=2, taken and not taken
        clear_mem();
        mem[0] = 16'h2800; mem[1] = 16'h0010; mem[16'h0010] = 16'h1002;
        mem[16'h0011] = 16'hF800; mem[16'h0013] = 16'hF800;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            bus.cmp_true = (t == 0);
            push(16'h0000, 16'h2800, 16'h0010);
            push(16'h0010, 16'h1002, 16'h0000);
            push((t == 0) ? 16'h0013 : 16'h0011, 16'hF800, 16'h0000);
            start();
            wait_done("cmp");
            chk("cmp_pc", 32'(pc), (t == 0) ? 32'h0013 : 32'h0011);
        end
        bus.cmp_true = 1'b0;

        // CAL 0100 from 0020, RTN to 0022, RTN underflow, restart at 0023
        clear_mem();
        do_reset();
        mem[0] = 16'h2800; mem[1] = 16'h0020;
        mem[16'h0020] = 16'h0800; mem[16'h0021] = 16'h0100;
        mem[16'h0100] = 16'hE000;
        mem[16'h0022] = 16'hE000; mem[16'h0023] = 16'hF800;
        push(16'h0000, 16'h2800, 16'h0020);
        push(16'h0020, 16'h0800, 16'h0100);
        push(16'h0100, 16'hE000, 16'h0000);
        push(16'h0022, 16'hE000, 16'h0000);
        start();
        wait_done("rtn");
        chk("rtn_uflow_pc",    32'(pc),    32'h0022);
        chk("rtn_uflow_fault", 32'(fault), 32'd1);
        push(16'h0023, 16'hF800, 16'h0000);
        start();
        chk("restart_pc",     32'(pc),     32'h0023);
        chk("restart_halted", 32'(halted), 32'd0);
        wait_done("restart");
        chk("fault_sticky", 32'(fault), 32'd1);

        // Five nested CALs overflow a 4-deep stack
        clear_mem();
        do_reset();
        for (int n = 0; n < 5; n++) begin
            mem[n * 16]     = 16'h0800;
            mem[n * 16 + 1] = 16'((n + 1) * 16);
            push(16'(n * 16), 16'h0800, 16'((n + 1) * 16));
        end
        start();
        wait_done("cal_ovf");
        chk("cal_ovf_pc",    32'(pc),    32'h0040);
        chk("cal_ovf_fault", 32'(fault), 32'd1);

        // Slow exec_done: single issue pulse, pc stable until done
        clear_mem();
        do_reset();
        bus.exec_done = 1'b0;
        mem[0] = 16'h4000; mem[1] = 16'hF800;
        push(16'h0000, 16'h4000, 16'h0000);
        push(16'h0001, 16'hF800, 16'h0000);
        start_count("slow", cyc);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("slow_issue_low", 32'(bus.issue), 32'd0);
            chk("slow_pc_hold",   32'(pc),        32'h0000);
        end
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        chk("slow_pc_after", 32'(pc), 32'h0001);
        wait_done("slow");

        // Reset in EXEC
        do_reset();
        push(16'h0000, 16'h4000, 16'h0000);
        start_count("rexec", cyc);
        tick();
        reset = 1'b1;
        tick();
        chk("rexec_pc",     32'(pc),             32'h0000);
        chk("rexec_addr",   32'(bus.instr_addr), 32'h0000);
        chk("rexec_ir",     32'(bus.ir),         32'h0000);
        chk("rexec_imm",    32'(bus.imm),        32'h0000);
        chk("rexec_issue",  32'(bus.issue),      32'd0);
        chk("rexec_halted", 32'(halted),         32'd0);
        chk("rexec_fault",  32'(fault),          32'd0);
        reset = 1'b0;

        // STP at FFFF, restart wraps to 0000
        clear_mem();
        do_reset();
        bus.exec_done = 1'b1;
        mem[0] = 16'h2800; mem[1] = 16'hFFFF; mem[16'hFFFF] = 16'hF800;
        push(16'h0000, 16'h2800, 16'hFFFF);
        push(16'hFFFF, 16'hF800, 16'h2800);
        start();
        wait_done("wrap");
        chk("wrap_stp_pc", 32'(pc), 32'hFFFF);
        push(16'h0000, 16'h2800, 16'hFFFF);
        push(16'hFFFF, 16'hF800, 16'h2800);
        start();
        chk("wrap_pc",   32'(pc),             32'h0000);
        chk("wrap_addr", 32'(bus.instr_addr), 32'h0000);
        wait_done("wrap2");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/issue controller for the 16-bit CPU. It owns the PC and reads 1- or 2-word instructions from synchronous instruction RAM (1-cycle read latency).
- It presents the latched instruction word (ir) and immediate (imm) to the decoder/datapath, then waits for execution to complete.
- It resolves next-PC for sequential, JMP, CMP-skip, CAL/RTN and STP.
- It replaces the combinational cnt_en/pc_sload/new_pc path with an explicit state machine plus a small return stack.

Parameters:
- STACK_DEPTH, 4, number of CAL return-address entries (power of two, 2..16).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- run  in  1  level; leaves IDLE/HALT and starts fetching at current pc.
- instr_addr  out  16  instruction RAM read address.
- instr_rddata  in  16  RAM data for the address presented the previous cycle.
- ir  out  16  latched instruction word.
- imm  out  16  latched second word (N); 0 for 1-word instructions.
- issue  out  1  one-cycle pulse: ir/imm valid, datapath starts execution.
- exec_done  in  1  datapath finished; sampled in ISSUE and EXEC states.
- cmp_true  in  1  CMP condition result; valid with exec_done.
- rd_data  in  16  Rd register value; JMP target when type=0.
- pc  out  16  current instruction address.
- halted  out  1  high in HALT state.
- fault  out  1  sticky; return-stack overflow or underflow.

Behaviour:
- Reset values: pc=RESET_PC, ir=0, imm=0, issue=0, halted=0, fault=0, instr_addr=RESET_PC, stack pointer sp=0, state=IDLE.
- Decode fields: op=ir[15:12], type=ir[11]. Classes:
  - STP: ir[15:11]=11111
  - CAL: 00001
  - RTN: 11100
  - CMP: op=0001
  - JMP: op=0010
- Instruction length: len = type ? 2 : 1. Exception: CAL is always 2 words.
- States:
  - IDLE: instr_addr=pc; on run go to FETCH.
  - FETCH: instr_addr=pc → WORD1.
  - WORD1: ir<=instr_rddata.
    - If the incoming word is 2-word: instr_addr=pc+1 → WORD2.
    - Otherwise imm<=0 → ISSUE.
  - WORD2: imm<=instr_rddata → ISSUE.
  - ISSUE: issue=1 for exactly this cycle. STP goes directly to HALT without waiting for exec_done. Otherwise, exec_done in this cycle resolves the PC → FETCH; else → EXEC.
  - EXEC: issue=0; wait for exec_done, then resolve the PC → FETCH.
  - HALT: halted=1; pc holds the STP address; run re-asserted → FETCH at pc+1.
- PC resolution, all arithmetic mod 2^16 (wraps at FFFF→0000):
  - JMP: pc <= type ? imm : rd_data.
  - CMP: pc <= pc + len + (cmp_true ? ir[1:0] : 0).
  - CAL: stack[sp]<=pc+2, sp++, pc<=imm. If sp==STACK_DEPTH: fault=1 → HALT, pc unchanged.
  - RTN: sp--, pc<=stack[sp-1]. If sp==0: fault=1 → HALT.
  - Other: pc <= pc + len.
- Latency: a 1-word non-branch instruction with exec_done in its ISSUE cycle takes 3 cycles (FETCH, WORD1, ISSUE); a 2-word one takes 4.
- exec_done or cmp_true outside ISSUE/EXEC are ignored.
- reset has priority over every event, including mid-WORD2 or mid-EXEC; the stack contents are discarded.
- run is ignored outside IDLE/HALT.
- fault clears only on reset; run from a fault HALT restarts at pc+1.

Optional Feature:
- Macro PC_SEQ_RETIRE_CNT_EN.
- When defined: extra output retired_cnt (out, 32). It resets to 0 and increments once per PC resolution, including STP and faulting CAL/RTN. It wraps at 2^32.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, run=1, RAM[0]=16'h4000 (1-word ADD), exec_done tied high → issue pulses at cycle 3 with ir=4000, imm=0; pc=1 at cycle 4.
- RAM[0]=16'h2800 (JMP type1), RAM[1]=16'h0050, exec_done=1 → ir=2800, imm=0050, issue at cycle 4, next instr_addr=0050.
- CMP at pc=10 with ir[1:0]=2, 1-word: cmp_true=1 → pc=13; cmp_true=0 → pc=11.
- CAL imm=0100 at pc=20 then RTN at 0100 → pc 0100 then 0022, sp back to 0. Five nested CALs with STACK_DEPTH=4 → fault=1, halted=1 on the 5th, pc unchanged.
- exec_done held low 5 cycles after issue → issue high exactly 1 cycle, pc stable until exec_done; reset asserted during EXEC → all outputs to reset values the next cycle.
- STP (16'hF800) at pc=FFFF → halted=1, pc=FFFF; run → fetch at 0000 (wrap).
